load_store_unit: RTL and testbench

Sits between the execute stage and the word-addressed data memory. Accepts byte, halfword and word load/store requests over a valid/ready handshake. Converts them into single-cycle word accesses: sub-word stores are a read-modify-write in one cycle, and load data is extracted and sign- or zero-extended. Misaligned requests are detected and reported without touching memory.

---
 rtl/load_store_unit_if.sv | 34 +++
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request, response and data-memory signals of the load/store unit.
// The slave modport is the unit's own view. The master modport is the
// environment's view: the execute stage plus the data memory.
interface load_store_unit_if;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqUnsigned;
    logic [31:0] reqAddress;
    logic [31:0] reqWriteData;
    logic        respValid;
    logic        respReady;
    logic [31:0] respData;
    logic        respMisaligned;
    logic [31:0] memAddress;
    logic        memWriteEnabled;
    logic [31:0] memWriteInput;
    logic [31:0] memReadResult;

    modport slave (
        input  reqValid, reqWrite, reqSize, reqUnsigned, reqAddress, reqWriteData,
        input  respReady, memReadResult,
        output reqReady, respValid, respData, respMisaligned,
        output memAddress, memWriteEnabled, memWriteInput
    );

    modport master (
        output reqValid, reqWrite, reqSize, reqUnsigned, reqAddress, reqWriteData,
        output respReady, memReadResult,
        input  reqReady, respValid, respData, respMisaligned,
        input  memAddress, memWriteEnabled, memWriteInput
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests into single-cycle word
// accesses. Sub-word stores merge into the word read in the same cycle.
// Loads are extracted and extended. Misaligned or illegal requests skip memory.
module load_store_unit (
    input  logic              clock,
    input  logic              reset,
    load_store_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        unsigned_ld;
        logic [31:0] address;
        logic [31:0] data;
    } req_t;

    state_t      state_q, state_d;
    req_t        req_q;
    logic [31:0] resp_data_q;
    logic        resp_mis_q;
    logic        req_mis;
    logic [31:0] shifted;
    logic [31:0] ld_ext;
    logic [31:0] merged;

    // Misalignment/illegal-size check on the incoming request.
    always_comb begin
        req_mis = 1'b0;
        case (bus.reqSize)
            2'b00:   req_mis = 1'b0;
            2'b01:   req_mis = bus.reqAddress[0];
            2'b10:   req_mis = |bus.reqAddress[1:0];
            default: req_mis = 1'b1;
        endcase
    end

    // Load extraction: shift the addressed lane down to bit 0, then extend.
    // An aligned half has address[0]=0, so the same shift selects its lane.
    always_comb begin
        shifted = bus.memReadResult >> {req_q.address[1:0], 3'b000};
        ld_ext  = bus.memReadResult;
        case (req_q.size)
            2'b00:   ld_ext = req_q.unsigned_ld ? {24'b0, shifted[7:0]}
                                                : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ld_ext = req_q.unsigned_ld ? {16'b0, shifted[15:0]}
                                                : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_ext = bus.memReadResult;
        endcase
    end

    // Store merge: replace only the addressed lane of the current word.
    always_comb begin
        merged = bus.memReadResult;
        case (req_q.size)
            2'b00:   merged[{req_q.address[1:0], 3'b000} +: 8]  = req_q.data[7:0];
            2'b01:   merged[{req_q.address[1], 4'b0000} +: 16] = req_q.data[15:0];
            default: merged = req_q.data;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and state-decoded outputs. Memory outputs depend only on
    // state so a reset during ACCESS drops the write enable immediately.
    always_comb begin
        state_d             = state_q;
        bus.reqReady        = 1'b0;
        bus.respValid       = 1'b0;
        bus.memAddress      = 32'b0;
        bus.memWriteEnabled = 1'b0;
        bus.memWriteInput   = 32'b0;
        case (state_q)
            IDLE: begin
                bus.reqReady = 1'b1;
                if (bus.reqValid) state_d = req_mis ? RESP : ACCESS;
            end
            ACCESS: begin
                bus.memAddress = req_q.address;
                if (req_q.write) begin
                    bus.memWriteEnabled = 1'b1;
                    bus.memWriteInput   = merged;
                end
                state_d = RESP;
            end
            RESP: begin
                bus.respValid = 1'b1;
                if (bus.respReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture and response registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_q       <= '0;
            resp_data_q <= 32'b0;
            resp_mis_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.reqValid) begin
                    req_q.write       <= bus.reqWrite;
                    req_q.size        <= bus.reqSize;
                    req_q.unsigned_ld <= bus.reqUnsigned;
                    req_q.address     <= bus.reqAddress;
                    req_q.data        <= bus.reqWriteData;
                    if (req_mis) begin
                        resp_data_q <= 32'b0;
                        resp_mis_q  <= 1'b1;
                    end
                end
                ACCESS: begin
                    resp_data_q <= req_q.write ? 32'b0 : ld_ext;
                    resp_mis_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.respData       = resp_data_q;
    assign bus.respMisaligned = resp_mis_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table run through a request
// task, plus sequences for back-pressure and reset during ACCESS.
module tb_load_store_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    load_store_unit_if bus();
    load_store_unit dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    // Word-indexed data memory: combinational read, write at the rising edge.
    logic [31:0] mem [0:31];
    assign bus.memReadResult = mem[bus.memAddress[6:2]];
    always @(posedge clock) if (bus.memWriteEnabled) mem[bus.memAddress[6:2]] <= bus.memWriteInput;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_mis;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic do_req(input vec_t v, input string tag);
        int cyc;
        int we;
        @(negedge clock);
        bus.reqWrite = v.wr; bus.reqSize = v.sz; bus.reqUnsigned = v.uns;
        bus.reqAddress = v.addr; bus.reqWriteData = v.wdata;
        bus.reqValid = 1'b1; bus.respReady = 1'b0;
        chk({tag, " reqReady"}, 32'(bus.reqReady), 32'd1);
        @(posedge clock); #1;
        bus.reqValid = 1'b0;
        cyc = 1; we = 0;
        while (!bus.respValid && cyc < 8) begin
            if (bus.memWriteEnabled) we++;
            @(posedge clock); #1;
            cyc++;
        end
        chk({tag, " respValid"}, 32'(bus.respValid), 32'd1);
        chk({tag, " latency"}, 32'(cyc), v.exp_mis ? 32'd1 : 32'd2);
        chk({tag, " respData"}, bus.respData, v.exp_data);
        chk({tag, " respMisaligned"}, 32'(bus.respMisaligned), 32'(v.exp_mis));
        chk({tag, " we cycles"}, 32'(we), (v.wr && !v.exp_mis) ? 32'd1 : 32'd0);
        chk({tag, " memAddress idle"}, bus.memAddress, 32'd0);
        bus.respReady = 1'b1;
        @(posedge clock); #1;
        bus.respReady = 1'b0;
        chk({tag, " back to idle"}, 32'(bus.reqReady), 32'd1);
        chk({tag, " mem word"}, mem[v.addr[6:2]], v.exp_mem);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[8] = 32'h11223344;
        bus.reqValid = 0; bus.reqWrite = 0; bus.reqSize = 0; bus.reqUnsigned = 0;
        bus.reqAddress = 0; bus.reqWriteData = 0; bus.respReady = 0;

        //          wr    sz     uns   addr    wdata          exp_data       mis   exp_mem
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h22, 32'h123456AA, 32'h00000000, 1'b0, 32'h11AA3344};
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h22, 32'h0,        32'hFFFFFFAA, 1'b0, 32'h11AA3344};
        vecs[4]  = '{1'b0, 2'b00, 1'b1, 32'h22, 32'h0,        32'h000000AA, 1'b0, 32'h11AA3344};
        vecs[5]  = '{1'b0, 2'b00, 1'b0, 32'h20, 32'h0,        32'h00000044, 1'b0, 32'h11AA3344};
        vecs[6]  = '{1'b0, 2'b00, 1'b0, 32'h23, 32'h0,        32'h00000011, 1'b0, 32'h11AA3344};
        vecs[7]  = '{1'b1, 2'b01, 1'b0, 32'h32, 32'hFFFF8001, 32'h00000000, 1'b0, 32'h80010000};
        vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h32, 32'h0,        32'hFFFF8001, 1'b0, 32'h80010000};
        vecs[9]  = '{1'b0, 2'b01, 1'b1, 32'h32, 32'h0,        32'h00008001, 1'b0, 32'h80010000};
        vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h30, 32'h0,        32'h00000000, 1'b0, 32'h80010000};
        vecs[11] = '{1'b1, 2'b10, 1'b0, 32'h41, 32'hCAFEF00D, 32'h00000000, 1'b1, 32'h00000000};
        vecs[12] = '{1'b0, 2'b01, 1'b0, 32'h43, 32'h0,        32'h00000000, 1'b1, 32'h00000000};
        vecs[13] = '{1'b1, 2'b11, 1'b0, 32'h40, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000};
        vecs[14] = '{1'b1, 2'b00, 1'b0, 32'h21, 32'h00000055, 32'h00000000, 1'b0, 32'h11AA5544};
        vecs[15] = '{1'b0, 2'b01, 1'b1, 32'h20, 32'h0,        32'h00005544, 1'b0, 32'h11AA5544};
        vecs[16] = '{1'b0, 2'b01, 1'b0, 32'h22, 32'h0,        32'h000011AA, 1'b0, 32'h11AA5544};

        // Reset state.
        #2;
        chk("rst reqReady", 32'(bus.reqReady), 32'd1);
        chk("rst respValid", 32'(bus.respValid), 32'd0);
        chk("rst respData", bus.respData, 32'd0);
        chk("rst respMisaligned", 32'(bus.respMisaligned), 32'd0);
        chk("rst memWriteEnabled", 32'(bus.memWriteEnabled), 32'd0);
        chk("rst memAddress", bus.memAddress, 32'd0);
        chk("rst memWriteInput", bus.memWriteInput, 32'd0);
        @(negedge clock); reset = 1'b0;

        for (int i = 0; i < 17; i++) do_req(vecs[i], $sformatf("vec%0d", i));

        // Back-pressure: response held while respReady is low; a second
        // request during the stall is ignored.
        @(negedge clock);
        bus.reqWrite = 0; bus.reqSize = 2'b10; bus.reqAddress = 32'h10; bus.reqValid = 1;
        @(posedge clock); #1;
        bus.reqValid = 0;
        cyc = 0;
        while (!bus.respValid && cyc < 8) begin @(posedge clock); #1; cyc++; end
        chk("bp respValid", 32'(bus.respValid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (i == 1) begin
                bus.reqWrite = 1; bus.reqSize = 2'b10; bus.reqAddress = 32'h10;
                bus.reqWriteData = 32'h0BADF00D; bus.reqValid = 1;
            end
            @(posedge clock); #1;
            chk($sformatf("bp%0d respValid", i), 32'(bus.respValid), 32'd1);
            chk($sformatf("bp%0d respData", i), bus.respData, 32'hDEADBEEF);
            chk($sformatf("bp%0d reqReady", i), 32'(bus.reqReady), 32'd0);
            chk($sformatf("bp%0d memWriteEnabled", i), 32'(bus.memWriteEnabled), 32'd0);
        end
        // Consume with reqValid still high: it must not be accepted this edge.
        @(negedge clock); bus.respReady = 1;
        @(posedge clock); #1;
        bus.reqValid = 0; bus.respReady = 0;
        chk("bp consume reqReady", 32'(bus.reqReady), 32'd1);
        chk("bp consume respValid", 32'(bus.respValid), 32'd0);
        @(posedge clock); #1;
        chk("bp no stray accept", 32'(bus.reqReady), 32'd1);
        chk("bp mem untouched", mem[4], 32'hDEADBEEF);
        do_req(vecs[1], "bp reload");

        // Reset during ACCESS of a byte store.
        @(negedge clock);
        bus.reqWrite = 1; bus.reqSize = 2'b00; bus.reqUnsigned = 0;
        bus.reqAddress = 32'h22; bus.reqWriteData = 32'h77; bus.reqValid = 1;
        @(posedge clock); #1;
        bus.reqValid = 0;
        chk("ar we in access", 32'(bus.memWriteEnabled), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar we dropped", 32'(bus.memWriteEnabled), 32'd0);
        chk("ar reqReady", 32'(bus.reqReady), 32'd1);
        chk("ar respValid", 32'(bus.respValid), 32'd0);
        chk("ar respData", bus.respData, 32'd0);
        chk("ar respMisaligned", 32'(bus.respMisaligned), 32'd0);
        chk("ar memAddress", bus.memAddress, 32'd0);
        chk("ar memWriteInput", bus.memWriteInput, 32'd0);
        @(posedge clock); #1;
        chk("ar mem unchanged", mem[8], 32'h11AA5544);
        @(negedge clock); reset = 1'b0;
        do_req('{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11AA5544, 1'b0, 32'h11AA5544}, "after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
